// File: rtl/exec_mem_responder.sv
// Memory-side responder for the EXEC data port. It serves reads after a fixed latency and commits writes
// on the sampling edge. It also has a backdoor preload port, a sticky protocol-error flag and transaction counters.
module exec_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  exec_rd_req,
    input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    output logic                  exec_rd_valid,
    output logic                  rd_busy,
    output logic                  protocol_err,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // RD_WAIT lasts RD_LATENCY-1 cycles and RESP adds one more, so the wait counter starts at RD_LATENCY-2.
    localparam int LAT_LOAD = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RESP
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            lat_cnt_q, lat_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  err_q, err_d;
    logic [15:0]           rd_count_q, rd_count_d;
    logic [15:0]           wr_count_q, wr_count_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic rd_accept;
    logic rd_drop;
    logic wr_blocked;
    logic wr_commit;
    logic resp_fire;

    assign rd_accept  = exec_rd_req && (state_q != ST_RD_WAIT);
    assign rd_drop    = exec_rd_req && (state_q == ST_RD_WAIT);
    assign wr_blocked = load_en && exec_wr_req && (exec_wr_addr == load_addr);
    assign wr_commit  = exec_wr_req && !wr_blocked;
    assign resp_fire  = (state_q == ST_RESP);

    // State register and all control/datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lat_cnt_q  <= '0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // NOTE: the word store has no reset; its contents change only through exec writes or the load port.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[exec_wr_addr] <= exec_wr_data;
        end
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: defaults first, so that no path through the case infers a latch.
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (exec_rd_req) begin
                    if (RD_LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d   = ST_RD_WAIT;
                        lat_cnt_d = 3'(LAT_LOAD);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (lat_cnt_q == 3'd0) begin
                    state_d = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values. Read data is taken in RESP, so earlier writes are visible.
    always_comb begin
        rd_addr_d  = rd_accept ? exec_rd_addr : rd_addr_q;
        rd_valid_d = resp_fire;
        rd_data_d  = resp_fire ? mem[rd_addr_q] : rd_data_q;
        rd_count_d = rd_count_q + 16'(resp_fire);
        wr_count_d = wr_count_q + 16'(wr_commit);
        err_d      = err_q | rd_drop | (load_en & (exec_rd_req | exec_wr_req));
    end

    assign exec_rd_data  = rd_data_q;
    assign exec_rd_valid = rd_valid_q;
    assign rd_busy       = (state_q == ST_RD_WAIT);
    assign protocol_err  = err_q;
    assign rd_count      = rd_count_q;
    assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_exec_mem_responder.sv
// Directed bench for exec_mem_responder: three instances (RD_LATENCY 1/2/3) share one stimulus stream.
module tb_exec_mem_responder;

    localparam int AW = 12;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          exec_rd_req;
    logic [AW-1:0] exec_rd_addr;
    logic          exec_wr_req;
    logic [AW-1:0] exec_wr_addr;
    logic [DW-1:0] exec_wr_data;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;

    logic [DW-1:0] d1, d2, d3;
    logic          v1, v2, v3;
    logic          b1, b2, b3;
    logic          e1, e2, e3;
    logic [15:0]   rc1, rc2, rc3;
    logic [15:0]   wc1, wc2, wc3;

    int errors = 0;
    int checks = 0;
    int pulses;

    always #5 clk = ~clk;

    exec_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr),
        .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .exec_rd_data(d1), .exec_rd_valid(v1), .rd_busy(b1), .protocol_err(e1),
        .rd_count(rc1), .wr_count(wc1)
    );

    exec_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset),
        .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr),
        .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .exec_rd_data(d2), .exec_rd_valid(v2), .rd_busy(b2), .protocol_err(e2),
        .rd_count(rc2), .wr_count(wc2)
    );

    exec_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset),
        .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr),
        .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .exec_rd_data(d3), .exec_rd_valid(v3), .rd_busy(b3), .protocol_err(e3),
        .rd_count(rc3), .wr_count(wc3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exec_rd_req  = 1'b0;
        exec_rd_addr = '0;
        exec_wr_req  = 1'b0;
        exec_wr_addr = '0;
        exec_wr_data = '0;
        load_en      = 1'b0;
        load_addr    = '0;
        load_data    = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_data", 32'(d1), 0);
        check("rst_valid", 32'(v1), 0);
        check("rst_busy", 32'(b3), 0);
        check("rst_err", 32'(e1), 0);
        check("rst_rdcnt", 32'(rc1), 0);
        check("rst_wrcnt", 32'(wc1), 0);

        // Preloaded word read back with latency 1
        preload(12'o200, 12'o1234);
        exec_rd_req = 1'b1; exec_rd_addr = 12'o200;
        tick();
        exec_rd_req = 1'b0; exec_rd_addr = 12'o7777;
        check("t1_valid_early", 32'(v1), 0);
        tick();
        check("t1_valid", 32'(v1), 1);
        check("t1_data", 32'(d1), 32'(12'o1234));
        tick();
        check("t1_valid_drop", 32'(v1), 0);
        check("t1_data_hold", 32'(d1), 32'(12'o1234));

        // Write then read
        exec_wr_req = 1'b1; exec_wr_addr = 12'o300; exec_wr_data = 12'o7777;
        tick();
        exec_wr_req = 1'b0;
        exec_rd_req = 1'b1; exec_rd_addr = 12'o300;
        tick();
        exec_rd_req = 1'b0;
        tick();
        check("t2_data", 32'(d1), 32'(12'o7777));
        check("t2_wrcnt", 32'(wc1), 1);

        // Same-cycle write and read to one address returns new data
        preload(12'o310, 12'o0001);
        exec_wr_req = 1'b1; exec_wr_addr = 12'o310; exec_wr_data = 12'o0052;
        exec_rd_req = 1'b1; exec_rd_addr = 12'o310;
        tick();
        clear_inputs();
        tick();
        check("t3_data", 32'(d1), 32'(12'o0052));
        check("t3_wrcnt", 32'(wc1), 2);
        check("t3_err", 32'(e1), 0);

        // Back-to-back reads at latency 1
        exec_rd_req = 1'b1; exec_rd_addr = 12'o200;
        tick();
        exec_rd_addr = 12'o300;
        tick();
        exec_rd_req = 1'b0;
        check("b2b_valid0", 32'(v1), 1);
        check("b2b_data0", 32'(d1), 32'(12'o1234));
        tick();
        check("b2b_valid1", 32'(v1), 1);
        check("b2b_data1", 32'(d1), 32'(12'o7777));
        check("b2b_rdcnt", 32'(rc1), 5);
        check("b2b_err", 32'(e1), 0);

        // Latency 3: overlapping request is dropped and flagged
        pulse_reset();
        check("t4_err_rst", 32'(e3), 0);
        exec_rd_req = 1'b1; exec_rd_addr = 12'o200;
        tick();
        exec_rd_addr = 12'o300;
        tick();
        exec_rd_req = 1'b0;
        check("t4_err", 32'(e3), 1);
        check("t4_busy", 32'(b3), 1);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (v3) pulses++;
            if (k == 1) begin
                check("t4_valid_at3", 32'(v3), 1);
                check("t4_data", 32'(d3), 32'(12'o1234));
            end
        end
        check("t4_pulses", 32'(pulses), 1);
        check("t4_rdcnt", 32'(rc3), 1);

        // Latency 2: reset mid-read discards the response
        pulse_reset();
        exec_rd_req = 1'b1; exec_rd_addr = 12'o200;
        tick();
        exec_rd_req = 1'b0;
        check("t5_busy", 32'(b2), 1);
        pulse_reset();
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (v2) pulses++;
        end
        check("t5_pulses", 32'(pulses), 0);
        check("t5_data", 32'(d2), 0);
        check("t5_busy_clr", 32'(b2), 0);
        check("t5_err", 32'(e2), 0);
        check("t5_rdcnt", 32'(rc2), 0);

        // rd_count wrap after 65537 reads
        pulse_reset();
        exec_rd_req = 1'b1; exec_rd_addr = 12'o200;
        for (int i = 0; i < 65537; i++) tick();
        check("t6_rdcnt_wrap0", 32'(rc1), 0);
        exec_rd_req = 1'b0;
        tick();
        check("t6_rdcnt_wrap1", 32'(rc1), 1);
        check("t6_err_clean", 32'(e1), 0);

        // Load with read in the same cycle flags a protocol error; the load still lands
        load_en = 1'b1; load_addr = 12'o400; load_data = 12'o0777;
        exec_rd_req = 1'b1; exec_rd_addr = 12'o200;
        tick();
        clear_inputs();
        check("t6_err_load", 32'(e1), 1);
        tick();
        exec_rd_req = 1'b1; exec_rd_addr = 12'o400;
        tick();
        exec_rd_req = 1'b0;
        tick();
        check("t6_load_data", 32'(d1), 32'(12'o0777));

        // Load beats exec write at the same address; a different address is still written
        load_en = 1'b1; load_addr = 12'o500; load_data = 12'o1111;
        exec_wr_req = 1'b1; exec_wr_addr = 12'o500; exec_wr_data = 12'o2222;
        tick();
        load_addr = 12'o520; load_data = 12'o3333;
        exec_wr_addr = 12'o510; exec_wr_data = 12'o4444;
        tick();
        clear_inputs();
        check("t6_wrcnt", 32'(wc1), 1);
        exec_rd_req = 1'b1; exec_rd_addr = 12'o500;
        tick();
        exec_rd_addr = 12'o510;
        tick();
        exec_rd_addr = 12'o520;
        check("t6_prio_data", 32'(d1), 32'(12'o1111));
        tick();
        exec_rd_req = 1'b0;
        check("t6_other_wr", 32'(d1), 32'(12'o4444));
        tick();
        check("t6_other_ld", 32'(d1), 32'(12'o3333));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
